// File: rtl/pkt_link_pkg.sv
// Shared definitions for the packet link: framing bytes, parser states,
// error classes, checksum modes and the checksum step used by both the
// RX parser and the TX packetiser.
package pkt_link_pkg;

    localparam logic [7:0] START_BYTE = 8'hAA;
    localparam logic [7:0] END_BYTE   = 8'h55;

    // Parser position within a frame: AA, TYPE, LEN, payload, CHK, 55.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TYPE = 3'd1,
        ST_LEN  = 3'd2,
        ST_PD   = 3'd3,
        ST_CHK  = 3'd4,
        ST_END  = 3'd5
    } parser_state_t;

    // Error classes reported on o_err_code.
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CHK     = 3'd1,
        ERR_END     = 3'd2,
        ERR_LEN     = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_OVF     = 3'd5
    } err_code_t;

    // Checksum flavour: running XOR or 8-bit sum with carries discarded.
    typedef enum logic {
        CHK_XOR = 1'b0,
        CHK_SUM = 1'b1
    } chk_mode_t;

    // One accumulation step of the frame checksum.
    function automatic logic [7:0] chk_step(input chk_mode_t mode,
                                            input logic [7:0] acc,
                                            input logic [7:0] din);
        logic [7:0] res;
        if (mode == CHK_SUM) begin
            res = acc + din;
        end else begin
            res = acc ^ din;
        end
        return res;
    endfunction

endpackage

// File: rtl/pkt_chk_accum.sv
// 8-bit frame checksum accumulator. clr zeroes the running value, acc_en
// folds din into it. The result is registered, so it reflects every byte
// accumulated on earlier cycles.
module pkt_chk_accum
    import pkt_link_pkg::*;
#(
    parameter int CHK_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       acc_en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    localparam chk_mode_t MODE = (CHK_MODE != 0) ? CHK_SUM : CHK_XOR;

    // Running checksum register; clear takes priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (acc_en) begin
            sum <= chk_step(MODE, sum, din);
        end
    end

endmodule

// File: rtl/pkt_stream_parser.sv
// Byte-stream packet parser between the UART RX and the packet consumer.
// Frames are AA, TYPE, LEN, LEN payload bytes, CHK, 55. Good packets whose
// type passes the filter are loaded into a one-deep output register; every
// malformed frame, timeout or overflow produces a one-cycle error pulse.
//
// Output handshake: o_valid rises together with o_data/o_len/o_type and all
// four hold steady until a cycle where o_valid && o_ready, which consumes the
// packet. A packet completing on that same cycle replaces the consumed one;
// a packet completing while the register is full and o_ready is low is
// dropped and reported as an overflow.
module pkt_stream_parser
    import pkt_link_pkg::*;
#(
    parameter int         MAX_PD_LEN  = 8,
    parameter int         CHK_MODE    = 0,
    parameter int         TIMEOUT_CYC = 1000,
    parameter logic [7:0] TYPE_MASK   = 8'h00,
    parameter logic [7:0] TYPE_MATCH  = 8'h00,
    parameter int         CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              i_data,
    input  logic                    i_valid,
    output logic [8*MAX_PD_LEN-1:0] o_data,
    output logic [7:0]              o_len,
    output logic [7:0]              o_type,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_err,
    output logic [2:0]              o_err_code,
    output logic [CNT_W-1:0]        o_pkt_cnt,
    output logic [CNT_W-1:0]        o_err_cnt
);

    localparam int PD_W = 8 * MAX_PD_LEN;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PD_LEN);

    // The idle counter only needs to count up to TIMEOUT_CYC-1: the cycle on
    // which it would reach TIMEOUT_CYC is the one that fires the timeout.
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    parser_state_t   state;
    logic [7:0]      type_q;
    logic [7:0]      len_q;
    logic [7:0]      cnt_q;
    logic [PD_W-1:0] pd_buf;
    logic [TO_W-1:0] idle_cnt;

    logic            acc_clr;
    logic            acc_en;
    logic [7:0]      chk_sum;

    logic            type_pass;
    logic            timeout_hit;
    logic            err_fire;
    err_code_t       err_code;
    logic            deliver;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == {CNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + CNT_W'(1);
        end
        return res;
    endfunction

    // Checksum covers TYPE, LEN and payload; a start byte begins a fresh sum.
    assign acc_clr = i_valid && (state == ST_IDLE) && (i_data == START_BYTE);
    assign acc_en  = i_valid && ((state == ST_TYPE) || (state == ST_LEN) || (state == ST_PD));

    pkt_chk_accum #(
        .CHK_MODE (CHK_MODE)
    ) u_chk_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .acc_en (acc_en),
        .din    (i_data),
        .sum    (chk_sum)
    );

    // Only the masked type bits have to equal TYPE_MATCH.
    assign type_pass = (((type_q ^ TYPE_MATCH) & TYPE_MASK) == 8'h00);

    // A byte arriving on the would-be timeout cycle wins over the timeout.
    assign timeout_hit = TO_EN && (state != ST_IDLE) && !i_valid && (idle_cnt == TO_LAST);

    // Classify the current cycle: at most one error, or a packet delivery.
    always_comb begin
        err_fire = 1'b0;
        err_code = ERR_NONE;
        deliver  = 1'b0;
        if (timeout_hit) begin
            err_fire = 1'b1;
            err_code = ERR_TIMEOUT;
        end else if (i_valid) begin
            case (state)
                ST_LEN: begin
                    if (i_data > MAX_LEN) begin
                        err_fire = 1'b1;
                        err_code = ERR_LEN;
                    end
                end
                ST_CHK: begin
                    if (i_data != chk_sum) begin
                        err_fire = 1'b1;
                        err_code = ERR_CHK;
                    end
                end
                ST_END: begin
                    if (i_data != END_BYTE) begin
                        err_fire = 1'b1;
                        err_code = ERR_END;
                    end else if (type_pass) begin
                        if (o_valid && !o_ready) begin
                            err_fire = 1'b1;
                            err_code = ERR_OVF;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame FSM: advances one step per received byte, aborts on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            type_q   <= 8'h00;
            len_q    <= 8'h00;
            cnt_q    <= 8'h00;
            pd_buf   <= '0;
            idle_cnt <= '0;
        end else begin
            if ((state == ST_IDLE) || i_valid || !TO_EN) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end

            if (timeout_hit) begin
                state <= ST_IDLE;
            end else if (i_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (i_data == START_BYTE) begin
                            state  <= ST_TYPE;
                            type_q <= 8'h00;
                            len_q  <= 8'h00;
                            cnt_q  <= 8'h00;
                            pd_buf <= '0;
                        end
                    end
                    ST_TYPE: begin
                        type_q <= i_data;
                        state  <= ST_LEN;
                    end
                    ST_LEN: begin
                        len_q <= i_data;
                        cnt_q <= 8'h00;
                        if (i_data > MAX_LEN) begin
                            state <= ST_IDLE;
                        end else if (i_data == 8'h00) begin
                            state <= ST_CHK;
                        end else begin
                            state <= ST_PD;
                        end
                    end
                    ST_PD: begin
                        for (int i = 0; i < MAX_PD_LEN; i++) begin
                            if (cnt_q == 8'(i)) begin
                                pd_buf[i*8 +: 8] <= i_data;
                            end
                        end
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == (len_q - 8'd1)) begin
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        state <= (i_data == chk_sum) ? ST_END : ST_IDLE;
                    end
                    ST_END: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output register, error pulse and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data     <= '0;
            o_len      <= 8'h00;
            o_type     <= 8'h00;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 3'd0;
            o_pkt_cnt  <= '0;
            o_err_cnt  <= '0;
        end else begin
            o_err      <= err_fire;
            o_err_code <= err_code;
            if (err_fire) begin
                o_err_cnt <= sat_inc(o_err_cnt);
            end

            if (deliver) begin
                o_valid   <= 1'b1;
                o_data    <= pd_buf;
                o_len     <= len_q;
                o_type    <= type_q;
                o_pkt_cnt <= sat_inc(o_pkt_cnt);
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pkt_stream_parser.sv
// Bench for pkt_stream_parser. Instance a: XOR checksum, 20-cycle timeout,
// no type filter, checked through a scoreboard of expected packets and
// error codes. Instance b: sum checksum, no timeout, type filter F0/00,
// checked inline. Both share the byte stream and o_ready.
module tb_pkt_stream_parser;

    localparam int PD_W  = 64;
    localparam int CNT_W = 16;
    localparam int PKT_W = 8 + 8 + PD_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       i_data;
    logic             i_valid;
    logic             o_ready;

    logic [PD_W-1:0]  a_data, b_data;
    logic [7:0]       a_len, a_type, b_len, b_type;
    logic             a_valid, b_valid, a_err, b_err;
    logic [2:0]       a_code, b_code;
    logic [CNT_W-1:0] a_pkt, a_errc, b_pkt, b_errc;

    int n_vec  = 0;
    int n_fail = 0;

    logic [PKT_W-1:0] exp_q[$];
    logic [2:0]       exp_err_q[$];
    logic [PKT_W-1:0] exp_pkt;
    logic [2:0]       exp_code;
    bit               a_held;
    int               exp_a_pkt;
    int               exp_a_err;

    always #5 clk = ~clk;

    pkt_stream_parser #(
        .MAX_PD_LEN(8), .CHK_MODE(0), .TIMEOUT_CYC(20),
        .TYPE_MASK(8'h00), .TYPE_MATCH(8'h00), .CNT_W(CNT_W)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_data(a_data), .o_len(a_len), .o_type(a_type), .o_valid(a_valid),
        .o_ready(o_ready), .o_err(a_err), .o_err_code(a_code),
        .o_pkt_cnt(a_pkt), .o_err_cnt(a_errc)
    );

    pkt_stream_parser #(
        .MAX_PD_LEN(8), .CHK_MODE(1), .TIMEOUT_CYC(0),
        .TYPE_MASK(8'hF0), .TYPE_MATCH(8'h00), .CNT_W(CNT_W)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_data(b_data), .o_len(b_len), .o_type(b_type), .o_valid(b_valid),
        .o_ready(o_ready), .o_err(b_err), .o_err_code(b_code),
        .o_pkt_cnt(b_pkt), .o_err_cnt(b_errc)
    );

    // Scoreboard monitor for instance a: packets popped on handshake,
    // error codes popped on every error pulse.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && a_valid && o_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pkt_unexpected: got type=%h len=%h data=%h, required no packet",
                             a_type, a_len, a_data);
                end else begin
                    exp_pkt = exp_q.pop_front();
                    if ({a_type, a_len, a_data} !== exp_pkt) begin
                        n_fail++;
                        $display("FAIL pkt_data: got %h, required %h", {a_type, a_len, a_data}, exp_pkt);
                    end
                end
            end
            if (rst_n && a_err) begin
                n_vec++;
                if (exp_err_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL err_unexpected: got code %0d, required no error", a_code);
                end else begin
                    exp_code = exp_err_q.pop_front();
                    if (a_code !== exp_code) begin
                        n_fail++;
                        $display("FAIL err_code: got %0d, required %0d", a_code, exp_code);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] calc_chk(input bit sum_mode, input logic [7:0] t,
                                            input logic [7:0] l, input logic [63:0] pd);
        logic [7:0] acc;
        acc = sum_mode ? (t + l) : (t ^ l);
        for (int i = 0; i < 8; i++) begin
            if (i < int'(l)) acc = sum_mode ? (acc + pd[i*8 +: 8]) : (acc ^ pd[i*8 +: 8]);
        end
        return acc;
    endfunction

    function automatic logic [63:0] mask_pd(input logic [63:0] pd, input logic [7:0] l);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(l)) m[i*8 +: 8] = pd[i*8 +: 8];
        end
        return m;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_data  = b;
        i_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        a_held    = 1'b0;
        exp_a_pkt = 0;
        exp_a_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Sends a whole frame and records what instance a must produce for it.
    task automatic send_frame(input logic [7:0] t, input logic [7:0] l, input logic [63:0] pd,
                              input logic [7:0] chk, input logic [7:0] endb);
        send_byte(8'hAA);
        send_byte(t);
        send_byte(l);
        if (l > 8'd8) begin
            exp_err_q.push_back(3'd3);
            exp_a_err++;
            return;
        end
        for (int i = 0; i < int'(l); i++) send_byte(pd[i*8 +: 8]);
        if (chk != calc_chk(1'b0, t, l, pd)) begin
            exp_err_q.push_back(3'd1);
            exp_a_err++;
        end else if (endb != 8'h55) begin
            exp_err_q.push_back(3'd2);
            exp_a_err++;
        end else if (a_held && !o_ready) begin
            exp_err_q.push_back(3'd5);
            exp_a_err++;
        end else begin
            exp_q.push_back({t, l, mask_pd(pd, l)});
            exp_a_pkt++;
            a_held = !o_ready;
        end
        send_byte(chk);
        send_byte(endb);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec += 8;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", a_valid); end
        if (a_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", a_err); end
        if (a_code !== 3'd0) begin n_fail++; $display("FAIL rst_code: got %0d, required 0", a_code); end
        if (a_data !== 64'h0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", a_data); end
        if (a_len !== 8'h0 || a_type !== 8'h0) begin n_fail++; $display("FAIL rst_len_type: got %h/%h, required 00/00", a_len, a_type); end
        if (a_pkt !== '0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d, required 0", a_pkt); end
        if (a_errc !== '0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d, required 0", a_errc); end
        if (b_valid !== 1'b0 || b_pkt !== '0) begin n_fail++; $display("FAIL rst_b: got valid %b cnt %0d, required 0 0", b_valid, b_pkt); end
    endtask

    task automatic test_xor_basic();
        logic [63:0] pd8;
        do_reset();
        send_frame(8'h01, 8'h02, 64'h3412, 8'h25, 8'h55);
        idle(1);
        n_vec += 5;
        if (a_valid !== 1'b1) begin n_fail++; $display("FAIL xor_valid: got %b, required 1", a_valid); end
        if (a_data !== 64'h3412) begin n_fail++; $display("FAIL xor_data: got %h, required 3412", a_data); end
        if (a_len !== 8'h02) begin n_fail++; $display("FAIL xor_len: got %h, required 02", a_len); end
        if (a_type !== 8'h01) begin n_fail++; $display("FAIL xor_type: got %h, required 01", a_type); end
        if (a_pkt !== CNT_W'(1)) begin n_fail++; $display("FAIL xor_pkt_cnt: got %0d, required 1", a_pkt); end
        // Full-length payload with random bytes.
        for (int i = 0; i < 8; i++) pd8[i*8 +: 8] = 8'($urandom_range(0, 255));
        send_frame(8'h10, 8'h08, pd8, calc_chk(1'b0, 8'h10, 8'h08, pd8), 8'h55);
        idle(3);
        n_vec += 2;
        if (a_pkt !== CNT_W'(exp_a_pkt)) begin n_fail++; $display("FAIL xor_max_cnt: got %0d, required %0d", a_pkt, exp_a_pkt); end
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL xor_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_sum_mode();
        do_reset();
        send_frame(8'h01, 8'h02, 64'h3412, 8'h49, 8'h55);
        idle(1);
        n_vec += 3;
        if (b_valid !== 1'b1) begin n_fail++; $display("FAIL sum_valid: got %b, required 1", b_valid); end
        if (b_data !== 64'h3412 || b_len !== 8'h02) begin n_fail++; $display("FAIL sum_data: got %h len %h, required 3412 len 02", b_data, b_len); end
        if (b_pkt !== CNT_W'(1)) begin n_fail++; $display("FAIL sum_pkt_cnt: got %0d, required 1", b_pkt); end
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h25);
        idle(1);
        n_vec += 3;
        if (b_err !== 1'b1 || b_code !== 3'd1) begin n_fail++; $display("FAIL sum_chk_err: got err %b code %0d, required 1 1", b_err, b_code); end
        if (b_valid !== 1'b0) begin n_fail++; $display("FAIL sum_chk_valid: got %b, required 0", b_valid); end
        if (b_errc !== CNT_W'(1)) begin n_fail++; $display("FAIL sum_err_cnt: got %0d, required 1", b_errc); end
        // Instance a sees a correct XOR checksum here and completes the frame.
        exp_q.push_back({8'h01, 8'h02, 64'h3412});
        exp_a_pkt++;
        send_byte(8'h55);
        idle(3);
        n_vec += 2;
        if (a_pkt !== CNT_W'(exp_a_pkt) || a_errc !== CNT_W'(exp_a_err)) begin n_fail++; $display("FAIL sum_a_cnts: got %0d/%0d, required %0d/%0d", a_pkt, a_errc, exp_a_pkt, exp_a_err); end
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL sum_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_len_err();
        do_reset();
        send_frame(8'h01, 8'h09, 64'h0, 8'h00, 8'h00);
        idle(1);
        n_vec += 2;
        if (a_err !== 1'b1 || a_code !== 3'd3) begin n_fail++; $display("FAIL len_err_a: got err %b code %0d, required 1 3", a_err, a_code); end
        if (b_err !== 1'b1 || b_code !== 3'd3) begin n_fail++; $display("FAIL len_err_b: got err %b code %0d, required 1 3", b_err, b_code); end
        send_frame(8'h05, 8'h01, 64'hA5, 8'hA1, 8'h55);
        idle(1);
        n_vec += 1;
        if (a_valid !== 1'b1 || a_type !== 8'h05 || a_len !== 8'h01) begin n_fail++; $display("FAIL len_recover: got v%b type %h len %h, required v1 05 01", a_valid, a_type, a_len); end
        // Bad end byte after a good checksum.
        send_frame(8'h06, 8'h01, 64'h10, 8'h17, 8'h54);
        idle(3);
        n_vec += 2;
        if (a_errc !== CNT_W'(exp_a_err)) begin n_fail++; $display("FAIL len_err_cnt: got %0d, required %0d", a_errc, exp_a_err); end
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL len_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_zero_len();
        do_reset();
        send_frame(8'h10, 8'h08, 64'h1122334455667788, calc_chk(1'b0, 8'h10, 8'h08, 64'h1122334455667788), 8'h55);
        send_frame(8'h07, 8'h00, 64'hFFFF, 8'h07, 8'h55);
        idle(1);
        n_vec += 2;
        if (a_valid !== 1'b1 || a_len !== 8'h00) begin n_fail++; $display("FAIL zero_len: got v%b len %h, required v1 00", a_valid, a_len); end
        if (a_data !== 64'h0) begin n_fail++; $display("FAIL zero_data: got %h, required 0", a_data); end
        idle(2);
        n_vec += 1;
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL zero_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hAA);
        send_byte(8'h01);
        exp_err_q.push_back(3'd4);
        exp_a_err++;
        // Iteration k is the k-th falling edge after the edge that sampled 01;
        // the timeout edge is 20 clocks after that sampling edge.
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            n_vec++;
            if (a_err !== (k == 21)) begin n_fail++; $display("FAIL timeout_k%0d: got err %b, required %b", k, a_err, (k == 21)); end
        end
        // A byte on the would-be timeout cycle keeps the frame alive.
        send_byte(8'hAA);
        send_byte(8'h01);
        idle(19);
        exp_q.push_back({8'h01, 8'h00, 64'h0});
        exp_a_pkt++;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h55);
        idle(3);
        n_vec += 3;
        if (a_pkt !== CNT_W'(1)) begin n_fail++; $display("FAIL timeout_pkt_cnt: got %0d, required 1", a_pkt); end
        if (a_errc !== CNT_W'(1)) begin n_fail++; $display("FAIL timeout_err_cnt: got %0d, required 1", a_errc); end
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL timeout_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        o_ready = 1'b0;
        send_frame(8'h01, 8'h02, 64'h3412, 8'h25, 8'h55);
        send_frame(8'h02, 8'h01, 64'h77, 8'h74, 8'h55);
        idle(1);
        n_vec += 3;
        if (a_err !== 1'b1 || a_code !== 3'd5) begin n_fail++; $display("FAIL ovf_err: got err %b code %0d, required 1 5", a_err, a_code); end
        if (a_pkt !== CNT_W'(1)) begin n_fail++; $display("FAIL ovf_pkt_cnt: got %0d, required 1", a_pkt); end
        if (a_errc !== CNT_W'(1)) begin n_fail++; $display("FAIL ovf_err_cnt: got %0d, required 1", a_errc); end
        idle(5);
        n_vec += 1;
        if (a_valid !== 1'b1 || a_type !== 8'h01 || a_data !== 64'h3412) begin n_fail++; $display("FAIL ovf_hold: got v%b type %h data %h, required v1 01 3412", a_valid, a_type, a_data); end
        o_ready = 1'b1;
        a_held  = 1'b0;
        idle(3);
        n_vec += 2;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_release: got %b, required 0", a_valid); end
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_replace();
        do_reset();
        o_ready = 1'b0;
        send_frame(8'h01, 8'h02, 64'h3412, 8'h25, 8'h55);
        idle(1);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'h74);
        exp_q.push_back({8'h02, 8'h01, 64'h77});
        exp_a_pkt++;
        @(negedge clk);
        o_ready = 1'b1;
        i_data  = 8'h55;
        i_valid = 1'b1;
        idle(1);
        a_held = 1'b0;
        n_vec += 2;
        if (a_valid !== 1'b1 || a_type !== 8'h02) begin n_fail++; $display("FAIL replace_valid: got v%b type %h, required v1 02", a_valid, a_type); end
        if (a_pkt !== CNT_W'(2) || a_errc !== '0) begin n_fail++; $display("FAIL replace_cnts: got %0d/%0d, required 2/0", a_pkt, a_errc); end
        idle(3);
        n_vec += 1;
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL replace_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_filter();
        do_reset();
        send_frame(8'h80, 8'h01, 64'h02, 8'h83, 8'h55);
        idle(1);
        n_vec += 3;
        if (b_valid !== 1'b0 || b_err !== 1'b0) begin n_fail++; $display("FAIL filter_b: got valid %b err %b, required 0 0", b_valid, b_err); end
        if (b_pkt !== '0 || b_errc !== '0) begin n_fail++; $display("FAIL filter_b_cnts: got %0d/%0d, required 0/0", b_pkt, b_errc); end
        if (a_valid !== 1'b1 || a_type !== 8'h80) begin n_fail++; $display("FAIL filter_a: got v%b type %h, required v1 80", a_valid, a_type); end
        idle(2);
        n_vec += 1;
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL filter_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        o_ready = 1'b0;
        send_frame(8'h01, 8'h02, 64'h3412, 8'h25, 8'h55);
        idle(1);
        n_vec += 1;
        if (a_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_held: got %b, required 1", a_valid); end
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        // The held packet is lost with the reset.
        exp_q.delete();
        exp_err_q.delete();
        a_held = 1'b0;
        exp_a_pkt = 0;
        exp_a_err = 0;
        #1;
        n_vec += 3;
        if (a_valid !== 1'b0 || a_err !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got valid %b err %b, required 0 0", a_valid, a_err); end
        if (a_data !== 64'h0 || a_len !== 8'h0 || a_type !== 8'h0) begin n_fail++; $display("FAIL rmid_outs: got %h %h %h, required 0 0 0", a_data, a_len, a_type); end
        if (a_pkt !== '0 || a_errc !== '0) begin n_fail++; $display("FAIL rmid_cnts: got %0d/%0d, required 0/0", a_pkt, a_errc); end
        @(negedge clk);
        rst_n   = 1'b1;
        o_ready = 1'b1;
        send_frame(8'h03, 8'h02, 64'h2211, 8'h32, 8'h55);
        idle(1);
        n_vec += 2;
        if (a_valid !== 1'b1 || a_pkt !== CNT_W'(1)) begin n_fail++; $display("FAIL rmid_next: got v%b cnt %0d, required v1 1", a_valid, a_pkt); end
        if (a_errc !== '0) begin n_fail++; $display("FAIL rmid_no_err: got %0d, required 0", a_errc); end
        idle(2);
        n_vec += 1;
        if (exp_q.size() != 0 || exp_err_q.size() != 0) begin n_fail++; $display("FAIL rmid_drain: %0d pkts %0d errs left, required 0 0", exp_q.size(), exp_err_q.size()); end
    endtask

    initial begin
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b1;
        test_reset();
        test_xor_basic();
        test_sum_mode();
        test_len_err();
        test_zero_len();
        test_timeout();
        test_back_to_back();
        test_replace();
        test_filter();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_stream_parser.md
Name: pkt_stream_parser

Overview:
Next-generation byte-stream packet parser for the packet link.
- Consumes UART bytes and accepts variable-length payloads up to MAX_PD_LEN.
- Supports selectable checksum mode, inter-byte timeout, type filtering and a valid/ready output register.
- Reports classified errors and counts packets and errors.
- Sits between the UART RX and the packet consumer.

Parameters:
MAX_PD_LEN, 8, maximum payload bytes (1..255); sets o_data width.
CHK_MODE, 0, 0 = XOR of type/len/payload bytes; 1 = 8-bit sum mod 256 of the same bytes.
TIMEOUT_CYC, 1000, idle cycles between bytes mid-packet before abort; 0 disables timeout.
TYPE_MASK, 8'h00, type bits that must match TYPE_MATCH; 8'h00 accepts all types.
TYPE_MATCH, 8'h00, required type value under TYPE_MASK.
CNT_W, 16, width of the packet and error counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_data  in  8  received byte
i_valid  in  1  byte strobe; one byte per asserted cycle
o_data  out  8*MAX_PD_LEN  payload; first received byte in [7:0]; unused upper bytes zero
o_len  out  8  payload length of the held packet
o_type  out  8  type byte of the held packet
o_valid  out  1  held packet valid
o_ready  in  1  consumer accepts the held packet when o_valid && o_ready
o_err  out  1  one-cycle error pulse
o_err_code  out  3  error class, valid while o_err=1
o_pkt_cnt  out  CNT_W  good packets delivered to the output register (saturating)
o_err_cnt  out  CNT_W  errors flagged (saturating)

Behaviour:
- Reset: one clock, asynchronous active-low reset. All outputs and counters are 0 and the FSM is in IDLE.
- Frame format: AA, TYPE, LEN, LEN payload bytes, CHK, 55.
- FSM states: IDLE, TYPE, LEN, PD, CHK, END. The state advances only on cycles where i_valid=1.
  - IDLE: waits for AA. Any other byte is ignored silently. On AA, clears the accumulators and payload buffer.
  - TYPE: latches TYPE and seeds the checksum.
  - LEN: latches LEN.
    - LEN > MAX_PD_LEN: error 3 (LEN), return to IDLE.
    - LEN = 0: go directly to CHK.
  - PD: writes the byte at index cnt and increments cnt. After byte LEN-1, go to CHK.
  - CHK: compares the byte with the accumulator.
    - Mismatch: error 1 (CHK), return to IDLE.
    - Match: go to END.
  - END:
    - Byte != 55: error 2 (END).
    - Byte = 55 and the type passes the filter: deliver the packet.
    - Byte = 55 and the type is filtered out: drop silently, no error.
    - In every case, return to IDLE.
- Resync: an AA byte received in any non-IDLE state is treated as data. There is no mid-packet resync; recovery is via timeout.
- Timeout:
  - The idle counter runs in any non-IDLE state and resets on every i_valid.
  - When it reaches TIMEOUT_CYC: error 4 (TIMEOUT), return to IDLE.
  - If i_valid arrives on the same cycle the counter reaches TIMEOUT_CYC, the byte wins and no timeout fires.
- Delivery:
  - o_valid rises on the cycle after the END byte is sampled, together with o_data, o_len and o_type.
  - Held outputs stay stable until the handshake o_valid && o_ready completes.
  - If o_ready=1 on the same cycle a new packet completes, the old packet is consumed and the new one is loaded, so o_valid stays 1.
  - If o_valid=1 and o_ready=0 when a new packet completes, the new packet is dropped and error 5 (OVF) is flagged.
- Error reporting:
  - o_err rises on the cycle after the offending byte, or the timeout cycle. At most one error is reported per cycle.
  - o_err_cnt increments once per error.
  - o_pkt_cnt increments once per loaded packet.
  - Both counters saturate at all-ones.
- Checksum: 8-bit accumulator over TYPE, LEN and payload bytes. XOR or sum is selected by CHK_MODE; sum carries are discarded.
- Reset mid-packet: the FSM aborts immediately. The held packet is lost and no error is reported.

Decomposition:
- Shared package pkt_link_pkg: START_BYTE=8'hAA, END_BYTE=8'h55, the parser state enum, the err_code enum (NONE=0, CHK=1, END=2, LEN=3, TIMEOUT=4, OVF=5), and the chk_mode enum.
- One sub-module, pkt_chk_accum: clear/accumulate controls, CHK_MODE parameter, 8-bit registered sum. It is reused by the TX packetiser.

Test Plan:
- XOR mode, MAX_PD_LEN=8, o_ready=1, bytes AA 01 02 12 34 25 55 → one cycle after 55: o_valid=1, o_data[15:0]=16'h3412, upper bytes 0, o_len=2, o_type=01, o_pkt_cnt=1.
- CHK_MODE=1, same frame with CHK=49 → delivered. Same frame with CHK=25 → o_err=1, o_err_code=1, o_valid stays 0, o_err_cnt=1.
- LEN=09 with MAX_PD_LEN=8 → error 3 after the LEN byte. A following valid frame is parsed correctly.
- LEN=00, frame AA 07 00 07 55 → o_valid=1, o_len=0, o_data=0.
- TIMEOUT_CYC=20, send AA 01 then 25 idle cycles → o_err_code=4 twenty cycles after the last byte. The next frame parses.
- o_ready held 0, two back-to-back good frames → first held stable, second gives error 5, o_pkt_cnt=1. Separately, rst_n pulsed mid-payload → all outputs 0 and the next frame parses.
